// File: rtl/seg7_capture_pkg.sv
// seg7_capture_pkg
//   Constants shared by the 7-segment scan-bus capture logic.
//   - GLYPHS      : pin patterns (active-low, dp off) for hex digits 0..F
//   - SEG_A/SEG_G : bit range of the segment lines within the 8-bit bus
//   - SEG_DP      : bit index of the decimal point
//   - SEG_ON      : electrical level of a lit segment / selected digit
//   - NUM_DIGITS  : digits on the scan bus
package seg7_capture_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam logic SEG_ON = 1'b0;

  localparam logic [7:0] GLYPHS [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // True when exactly one select line is at the active level.
  function automatic logic sel_legal(input logic [3:0] sel_n);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (sel_n[i] == SEG_ON) n++;
    return (n == 1);
  endfunction

  // Index of the active select line (meaningful only when sel_legal).
  function automatic logic [1:0] sel_index(input logic [3:0] sel_n);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (sel_n[i] == SEG_ON) idx = i[1:0];
    return idx;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode
//   Combinational decode of a 7-bit active-low segment pattern {g..a}
//   to a hex nibble.
//   Ports:
//     i_pattern : segment lines {g,f,e,d,c,b,a}, active-low
//     o_hit     : pattern is one of the 16 hex glyphs
//     o_nibble  : decoded value, 0 when o_hit is low
module seg7_glyph_decode
  import seg7_capture_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic       o_hit,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_hit    = 1'b0;
    o_nibble = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i_pattern == GLYPHS[i][6:0]) begin
        o_hit    = 1'b1;
        o_nibble = i[3:0];
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// seg7_capture
//   Monitors a multiplexed 7-segment scan bus and reassembles the 16-bit
//   displayed word. A digit is sampled once its one-hot select has been
//   stable for SETTLE_CYCLES cycles; when all four digits are captured the
//   frame is published. stale flags a bus that stopped scanning.
//   Build option: define SEG7_CAPTURE_SYNC_EN to add a 2-flop synchroniser
//   on seg_in/segsel_in for asynchronous sources (+2 cycles latency).
//   Ports:
//     clk         : system clock
//     reset       : asynchronous active-low reset
//     seg_in      : segment bus {dp,g,f,e,d,c,b,a}, active-low
//     segsel_in   : digit select, active-low one-hot, bit0 = value[3:0]
//     value       : last complete decoded frame
//     dp          : decimal point per digit of last frame (1 = lit)
//     digit_err   : per digit, last frame pattern was not a hex glyph
//     frame_valid : one-cycle pulse when value/dp/digit_err update
//     stale       : no digit sampled for TIMEOUT_CYCLES cycles
module seg7_capture
  import seg7_capture_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  seg_in,
  input  logic [3:0]  segsel_in,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        stale
);

  localparam logic [7:0]  SETTLE  = 8'(SETTLE_CYCLES);
  localparam logic [19:0] TIMEOUT = 20'(TIMEOUT_CYCLES);

  logic [7:0] w_seg;
  logic [3:0] w_sel;

`ifdef SEG7_CAPTURE_SYNC_EN
  logic [7:0] r_seg_s1, r_seg_s2;
  logic [3:0] r_sel_s1, r_sel_s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
      r_sel_s1 <= '1;
      r_sel_s2 <= '1;
    end else begin
      r_seg_s1 <= seg_in;
      r_seg_s2 <= r_seg_s1;
      r_sel_s1 <= segsel_in;
      r_sel_s2 <= r_sel_s1;
    end
  end

  assign w_seg = r_seg_s2;
  assign w_sel = r_sel_s2;
`else
  assign w_seg = seg_in;
  assign w_sel = segsel_in;
`endif

  logic [3:0]  r_prev_sel;
  logic [7:0]  r_stable;
  logic [3:0]  r_shadow [4];
  logic [3:0]  r_shadow_dp;
  logic [3:0]  r_shadow_err;
  logic [3:0]  r_mask;
  logic [19:0] r_to;

  logic        w_legal;
  logic [1:0]  w_idx;
  logic [7:0]  w_stable_nxt;
  logic        w_sample;
  logic        w_publish;
  logic        w_timeout;
  logic        w_hit;
  logic [3:0]  w_nibble;

  seg7_glyph_decode u_decode (
    .i_pattern (w_seg[SEG_G:SEG_A]),
    .o_hit     (w_hit),
    .o_nibble  (w_nibble)
  );

  assign w_legal = sel_legal(w_sel);
  assign w_idx   = sel_index(w_sel);

  // Counter saturates at SETTLE, so the sample strobe fires exactly once
  // per dwell; a new select restarts at 1 (which samples when SETTLE==1).
  always_comb begin
    w_stable_nxt = '0;
    w_sample     = 1'b0;
    if (w_legal) begin
      if (w_sel != r_prev_sel) begin
        w_stable_nxt = 8'd1;
        w_sample     = (SETTLE == 8'd1);
      end else if (r_stable != SETTLE) begin
        w_stable_nxt = r_stable + 8'd1;
        w_sample     = (w_stable_nxt == SETTLE);
      end else begin
        w_stable_nxt = r_stable;
      end
    end
  end

  assign w_publish = (r_mask == '1);
  assign w_timeout = !w_sample && (r_to != TIMEOUT) && ((r_to + 20'd1) == TIMEOUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_sel   <= '1;
      r_stable     <= '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= '0;
      r_shadow_dp  <= '0;
      r_shadow_err <= '0;
      r_mask       <= '0;
      r_to         <= '0;
      value        <= '0;
      dp           <= '0;
      digit_err    <= '0;
      frame_valid  <= 1'b0;
      stale        <= 1'b1;
    end else begin
      r_prev_sel  <= w_sel;
      r_stable    <= w_stable_nxt;
      frame_valid <= w_publish;

      if (w_sample)                 r_to <= '0;
      else if (r_to != TIMEOUT)     r_to <= r_to + 20'd1;

      if (w_publish) begin
        value     <= {r_shadow[3], r_shadow[2], r_shadow[1], r_shadow[0]};
        dp        <= r_shadow_dp;
        digit_err <= r_shadow_err;
        stale     <= 1'b0;
      end
      if (w_timeout) stale <= 1'b1;

      // Clear first so a sample coinciding with publish survives in the mask.
      if (w_publish || w_timeout) r_mask <= '0;
      if (w_sample) begin
        r_shadow[w_idx]     <= w_nibble;
        r_shadow_dp[w_idx]  <= (w_seg[SEG_DP] == SEG_ON);
        r_shadow_err[w_idx] <= !w_hit;
        if (w_publish) r_mask <= 4'b0001 << w_idx;
        else           r_mask <= r_mask | (4'b0001 << w_idx);
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;

  logic        clk;
  logic        reset;
  logic [7:0]  seg_in;
  logic [3:0]  segsel_in;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        stale;

  int tests = 0;
  int fails = 0;
  int fv_count = 0;

`ifdef SEG7_CAPTURE_SYNC_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 5;
`endif

  logic [7:0] GLY [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  seg7_capture #(
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .segsel_in   (segsel_in),
    .value       (value),
    .dp          (dp),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .stale       (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (frame_valid === 1'b1) fv_count++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input int d, input logic [7:0] pat, input int dwell);
    segsel_in = ~(4'b0001 << d);
    seg_in    = pat;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic blank(input int n);
    segsel_in = '1;
    seg_in    = '1;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [15:0] w, input int dwell);
    for (int d = 0; d < 4; d++) drive(d, GLY[w[d*4 +: 4]], dwell);
    blank(4);
  endtask

  task automatic test_reset;
    tests++; if (value !== 16'h0) begin fails++; $display("FAIL reset_value: got %h want %h", value, 16'h0); end
    tests++; if (dp !== 4'h0) begin fails++; $display("FAIL reset_dp: got %h want %h", dp, 4'h0); end
    tests++; if (digit_err !== 4'h0) begin fails++; $display("FAIL reset_err: got %h want %h", digit_err, 4'h0); end
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
    tests++; if (stale !== 1'b1) begin fails++; $display("FAIL reset_stale: got %b want 1", stale); end
    reset = 1'b1;
    blank(2);
    tests++; if (stale !== 1'b1) begin fails++; $display("FAIL reset_stale_hold: got %b want 1", stale); end
  endtask

  task automatic test_scan;
    int c0;
    c0 = fv_count;
    scan(16'h1234, 8);
    tests++; if (fv_count - c0 !== 1) begin fails++; $display("FAIL scan_frames: got %0d want 1", fv_count - c0); end
    tests++; if (value !== 16'h1234) begin fails++; $display("FAIL scan_value: got %h want %h", value, 16'h1234); end
    tests++; if (digit_err !== 4'h0) begin fails++; $display("FAIL scan_err: got %h want %h", digit_err, 4'h0); end
    tests++; if (dp !== 4'h0) begin fails++; $display("FAIL scan_dp: got %h want %h", dp, 4'h0); end
    tests++; if (stale !== 1'b0) begin fails++; $display("FAIL scan_stale: got %b want 0", stale); end
  endtask

  task automatic test_latency;
    int c0;
    int n;
    bit seen;
    c0 = fv_count;
    drive(0, GLY[1], 8);
    drive(1, GLY[2], 8);
    drive(2, GLY[3], 8);
    segsel_in = 4'b0111;
    seg_in    = GLY[4];
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (frame_valid === 1'b1) seen = 1'b1;
    end
    tests++; if (!seen || n != LAT) begin fails++; $display("FAIL latency: got %0d cycles (seen=%0b) want %0d", n, seen, LAT); end
    repeat (15) @(negedge clk);
    blank(4);
    tests++; if (fv_count - c0 !== 1) begin fails++; $display("FAIL latency_frames: got %0d want 1", fv_count - c0); end
    tests++; if (value !== 16'h4321) begin fails++; $display("FAIL latency_value: got %h want %h", value, 16'h4321); end
  endtask

  task automatic test_short_dwell;
    int c0;
    c0 = fv_count;
    scan(16'hFFFF, 3);
    tests++; if (fv_count - c0 !== 0) begin fails++; $display("FAIL short_frames: got %0d want 0", fv_count - c0); end
    tests++; if (value !== 16'h4321) begin fails++; $display("FAIL short_hold: got %h want %h", value, 16'h4321); end
    scan(16'h5678, 8);
    tests++; if (fv_count - c0 !== 1) begin fails++; $display("FAIL short_then_full_frames: got %0d want 1", fv_count - c0); end
    tests++; if (value !== 16'h5678) begin fails++; $display("FAIL short_then_full_value: got %h want %h", value, 16'h5678); end
  endtask

  task automatic test_blank_digit;
    int c0;
    c0 = fv_count;
    drive(0, GLY[12], 8);
    drive(1, GLY[5] & 8'h7F, 8);
    drive(2, 8'hFF, 8);
    drive(3, GLY[9], 8);
    blank(4);
    tests++; if (fv_count - c0 !== 1) begin fails++; $display("FAIL blank_frames: got %0d want 1", fv_count - c0); end
    tests++; if (value !== 16'h905C) begin fails++; $display("FAIL blank_value: got %h want %h", value, 16'h905C); end
    tests++; if (digit_err !== 4'b0100) begin fails++; $display("FAIL blank_err: got %b want %b", digit_err, 4'b0100); end
    tests++; if (dp !== 4'b0010) begin fails++; $display("FAIL blank_dp: got %b want %b", dp, 4'b0010); end
  endtask

  task automatic test_illegal_sel;
    int c0;
    c0 = fv_count;
    drive(0, GLY[10], 8);
    drive(1, GLY[6], 8);
    segsel_in = 4'b1100;
    seg_in    = GLY[8];
    repeat (10) @(negedge clk);
    tests++; if (fv_count - c0 !== 0) begin fails++; $display("FAIL twohot_frames: got %0d want 0", fv_count - c0); end
    blank(10);
    drive(2, GLY[12], 8);
    drive(3, GLY[3], 8);
    blank(4);
    tests++; if (fv_count - c0 !== 1) begin fails++; $display("FAIL illegal_frames: got %0d want 1", fv_count - c0); end
    tests++; if (value !== 16'h3C6A) begin fails++; $display("FAIL illegal_value: got %h want %h", value, 16'h3C6A); end
  endtask

  task automatic test_timeout;
    int c0;
    drive(0, GLY[7], 8);
    drive(1, GLY[7], 8);
    segsel_in = '1;
    seg_in    = '1;
    // Now 4 edges past the last sample; timeout hits on edge 100.
    repeat (95) @(negedge clk);
    tests++; if (stale !== 1'b0) begin fails++; $display("FAIL stale_early: got %b want 0", stale); end
    @(negedge clk);
    tests++; if (stale !== 1'b1) begin fails++; $display("FAIL stale_at_timeout: got %b want 1", stale); end
    c0 = fv_count;
    drive(2, GLY[14], 8);
    drive(3, GLY[11], 8);
    blank(4);
    tests++; if (fv_count - c0 !== 0) begin fails++; $display("FAIL timeout_leftover: got %0d frames want 0", fv_count - c0); end
    tests++; if (stale !== 1'b1) begin fails++; $display("FAIL stale_after_sample: got %b want 1", stale); end
    drive(0, GLY[15], 8);
    drive(1, GLY[14], 8);
    blank(4);
    tests++; if (fv_count - c0 !== 1) begin fails++; $display("FAIL timeout_frames: got %0d want 1", fv_count - c0); end
    tests++; if (value !== 16'hBEEF) begin fails++; $display("FAIL timeout_value: got %h want %h", value, 16'hBEEF); end
    tests++; if (stale !== 1'b0) begin fails++; $display("FAIL stale_cleared: got %b want 0", stale); end
  endtask

  task automatic test_reset_midframe;
    int c0;
    drive(0, GLY[13], 8);
    drive(1, GLY[12], 8);
    #2 reset = 1'b0;
    #1;
    tests++; if (value !== 16'h0) begin fails++; $display("FAIL midreset_value: got %h want %h", value, 16'h0); end
    tests++; if (stale !== 1'b1) begin fails++; $display("FAIL midreset_stale: got %b want 1", stale); end
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL midreset_fv: got %b want 0", frame_valid); end
    @(negedge clk);
    reset = 1'b1;
    c0 = fv_count;
    drive(2, GLY[0], 8);
    drive(3, GLY[0], 8);
    drive(0, GLY[0], 8);
    drive(1, GLY[15], 8);
    blank(4);
    tests++; if (fv_count - c0 !== 1) begin fails++; $display("FAIL midreset_frames: got %0d want 1", fv_count - c0); end
    tests++; if (value !== 16'h00F0) begin fails++; $display("FAIL midreset_next_value: got %h want %h", value, 16'h00F0); end
  endtask

  initial begin
    reset     = 1'b0;
    seg_in    = '1;
    segsel_in = '1;
    repeat (3) @(negedge clk);
    test_reset;
    test_scan;
    test_latency;
    test_short_dwell;
    test_blank_digit;
    test_illegal_sel;
    test_timeout;
    test_reset_midframe;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
